// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter_if
// Description : Request/response bundle between the write requesters and the
//               arbitrated shared-register write controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_write_arbiter_if #(
    parameter int N_REQ = 8,
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [N_REQ-1:0]       en;
    logic [N_REQ*WIDTH-1:0] d_in;
    logic                   cnt_clr;
    logic [WIDTH-1:0]       d_out;
    logic [N_REQ-1:0]       grant;
    logic                   wr_valid;
    logic                   conflict;
    logic [CNT_W-1:0]       conflict_cnt;

    // Requester side: drives enables/data, observes the register and status
    modport master (
        output en, d_in, cnt_clr,
        input  d_out, grant, wr_valid, conflict, conflict_cnt
    );

    // Controller side
    modport slave (
        input  en, d_in, cnt_clr,
        output d_out, grant, wr_valid, conflict, conflict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin arbitrated single write port for a shared data
//               register. Reports the winning requester and flags/counts
//               cycles in which several requesters wanted to write.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int               N_REQ     = 8,
    parameter int               WIDTH     = 1,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    reg_write_arbiter_if.slave bus
);
    localparam int               c_PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [c_PTR_W-1:0] rr_ptr_q,       rr_ptr_d;
    logic [WIDTH-1:0]   d_out_q,        d_out_d;
    logic [N_REQ-1:0]   grant_q,        grant_d;
    logic               wr_valid_q,     wr_valid_d;
    logic               conflict_q,     conflict_d;
    logic [CNT_W-1:0]   conflict_cnt_q, conflict_cnt_d;
    logic               found;

    // Next-state: round-robin winner search, register update, conflict tracking
    always_comb begin
        found          = 1'b0;
        rr_ptr_d       = rr_ptr_q;
        d_out_d        = d_out_q;
        grant_d        = '0;
        wr_valid_d     = 1'b0;

        // First pass: requesters at or above the pointer, lowest index first
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && bus.en[i] && (i >= int'(rr_ptr_q))) begin
                found      = 1'b1;
                grant_d[i] = 1'b1;
                d_out_d    = bus.d_in[i*WIDTH +: WIDTH];
                rr_ptr_d   = (i == N_REQ - 1) ? '0 : c_PTR_W'(i + 1);
            end
        end
        // Second pass wraps around; it can only hit indices below the pointer
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && bus.en[i]) begin
                found      = 1'b1;
                grant_d[i] = 1'b1;
                d_out_d    = bus.d_in[i*WIDTH +: WIDTH];
                rr_ptr_d   = (i == N_REQ - 1) ? '0 : c_PTR_W'(i + 1);
            end
        end
        wr_valid_d = found;

        // Two or more bits set iff clearing the lowest set bit leaves something
        conflict_d = ((bus.en & (bus.en - N_REQ'(1))) != '0);

        conflict_cnt_d = conflict_cnt_q;
        if (bus.cnt_clr) begin
            conflict_cnt_d = '0;
        end else if (conflict_d && (conflict_cnt_q != c_CNT_MAX)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset taking priority over all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            d_out_q        <= RESET_VAL;
            grant_q        <= '0;
            wr_valid_q     <= 1'b0;
            conflict_q     <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            d_out_q        <= d_out_d;
            grant_q        <= grant_d;
            wr_valid_q     <= wr_valid_d;
            conflict_q     <= conflict_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.d_out        = d_out_q;
    assign bus.grant        = grant_q;
    assign bus.wr_valid     = wr_valid_q;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_cnt = conflict_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Self-checking bench for reg_write_arbiter. Two instances share
//               stimulus: one with an 8-bit conflict counter, one with a 2-bit
//               counter to exercise saturation. Directed steps are followed by
//               random traffic checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;
    localparam int c_N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] en = '0;
    logic [7:0] d_in = '0;
    logic       cnt_clr = 1'b0;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int         m_ptr;
    logic       m_dout;
    logic [7:0] m_grant;
    logic       m_wr;
    logic       m_conf;
    int         m_cnt8;
    int         m_cnt2;

    reg_write_arbiter_if #(.N_REQ(8), .WIDTH(1), .CNT_W(8)) bus8 ();
    reg_write_arbiter_if #(.N_REQ(8), .WIDTH(1), .CNT_W(2)) bus2 ();

    assign bus8.en = en;   assign bus8.d_in = d_in;   assign bus8.cnt_clr = cnt_clr;
    assign bus2.en = en;   assign bus2.d_in = d_in;   assign bus2.cnt_clr = cnt_clr;

    reg_write_arbiter #(.N_REQ(8), .WIDTH(1), .CNT_W(8), .RESET_VAL(1'b0)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    reg_write_arbiter #(.N_REQ(8), .WIDTH(1), .CNT_W(2), .RESET_VAL(1'b0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance the model, then compare both DUTs
    task automatic cycle(input logic r, input logic [7:0] e, input logic [7:0] d, input logic c);
        bit found;
        int idx;
        rst = r; en = e; d_in = d; cnt_clr = c;
        @(posedge clk);
        if (r) begin
            m_ptr = 0; m_dout = 1'b0; m_grant = '0; m_wr = 1'b0; m_conf = 1'b0;
            m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            found = 1'b0;
            m_grant = '0;
            for (int k = 0; k < c_N; k++) begin
                idx = (m_ptr + k) % c_N;
                if (!found && e[idx]) begin
                    found = 1'b1;
                    m_dout = d[idx];
                    m_grant[idx] = 1'b1;
                    m_ptr = (idx + 1) % c_N;
                end
            end
            m_wr = found;
            m_conf = ($countones(e) >= 2);
            if (c) begin
                m_cnt8 = 0; m_cnt2 = 0;
            end else if (m_conf) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
        end
        #1;
        check("d_out",     32'(bus8.d_out),        32'(m_dout));
        check("grant",     32'(bus8.grant),        32'(m_grant));
        check("wr_valid",  32'(bus8.wr_valid),     32'(m_wr));
        check("conflict",  32'(bus8.conflict),     32'(m_conf));
        check("cnt8",      32'(bus8.conflict_cnt), 32'(m_cnt8));
        check("d_out_c2",  32'(bus2.d_out),        32'(m_dout));
        check("grant_c2",  32'(bus2.grant),        32'(m_grant));
        check("cnt2",      32'(bus2.conflict_cnt), 32'(m_cnt2));
    endtask

    initial begin
        logic [7:0] e;

        // 1: reset held with all requesters asserted
        cycle(1'b1, 8'hFF, 8'hFF, 1'b0);
        cycle(1'b1, 8'hFF, 8'hFF, 1'b0);
        check("rst_grant", 32'(bus8.grant), 32'h0);
        check("rst_cnt",   32'(bus8.conflict_cnt), 32'h0);

        // 2: single writer, then idle hold
        cycle(1'b0, 8'h08, 8'h08, 1'b0);
        check("single_dout",  32'(bus8.d_out), 32'h1);
        check("single_grant", 32'(bus8.grant), 32'h08);
        cycle(1'b0, 8'h00, 8'h00, 1'b0);
        check("idle_dout",  32'(bus8.d_out), 32'h1);
        check("idle_wr",    32'(bus8.wr_valid), 32'h0);

        // 3: full contention from reset, grants rotate
        cycle(1'b1, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 8'hFF, 8'($urandom), 1'b0);
            check("rot_grant", 32'(bus8.grant), 32'(1) << (k % 8));
        end
        check("cnt_ten", 32'(bus8.conflict_cnt), 32'd10);
        // 5: narrow counter saturated, clear beats a simultaneous conflict
        check("cnt_sat", 32'(bus2.conflict_cnt), 32'd3);
        cycle(1'b0, 8'hFF, 8'h00, 1'b1);
        check("clr_cnt8", 32'(bus8.conflict_cnt), 32'd0);
        check("clr_cnt2", 32'(bus2.conflict_cnt), 32'd0);

        // 4: grant to 6, then pointer wraps past 7
        cycle(1'b0, 8'h40, 8'h40, 1'b0);
        check("g6", 32'(bus8.grant), 32'h40);
        cycle(1'b0, 8'h05, 8'h01, 1'b0);
        check("wrap_g0", 32'(bus8.grant), 32'h01);
        cycle(1'b0, 8'h05, 8'h01, 1'b0);
        check("skip_g2", 32'(bus8.grant), 32'h04);

        // 6: reset in the middle of full contention
        cycle(1'b0, 8'hFF, 8'h00, 1'b0);
        check("pre_rst_g3", 32'(bus8.grant), 32'h08);
        cycle(1'b1, 8'hFF, 8'hFF, 1'b0);
        check("mid_rst_wr", 32'(bus8.wr_valid), 32'h0);
        cycle(1'b0, 8'hFF, 8'hFF, 1'b0);
        check("post_rst_g0", 32'(bus8.grant), 32'h01);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       e = 8'h01 << $urandom_range(0, 7);
                1:       e = 8'h00;
                default: e = 8'($urandom);
            endcase
            cycle(($urandom_range(0, 49) == 0), e, 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
